// File: rtl/cbus_arbiter_pkg.sv
// rtl/cbus_arbiter_pkg.sv - shared CBus request/response types for the arbiter slice
package cbus_arbiter_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } cbus_burst_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } cbus_size_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    cbus_burst_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  // A single requester still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first valid index at or after prio_ptr
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   prio_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, prio_ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - round-robin arbiter sharing one CBus bridge port among NUM_REQ masters
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  cbus_req_t  [NUM_REQ-1:0] ireqs,
  output cbus_resp_t [NUM_REQ-1:0] iresps,
  output cbus_req_t                oreq,
  input  cbus_resp_t               oresp,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   prio_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] req_valid;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = ireqs[i].valid;
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid    (req_valid),
    .prio_ptr (prio_ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio_ptr  <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (oresp.ready && oresp.last) begin
            busy     <= 1'b0;
            state    <= IDLE;
            prio_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The IDLE cycle forces valid low so the bridge re-enters its init state between transactions.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state == BUSY) begin
      oreq              = ireqs[grant_idx];
      iresps[grant_idx] = oresp;
    end
  end

  proto_hold : assert property (@(posedge clk) disable iff (reset)
    (state == BUSY) |-> ireqs[grant_idx].valid)
    else $warning("cbus_arbiter: grantee %0d dropped valid before ready&&last", grant_idx);

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb/tb_cbus_arbiter.sv - self-checking bench for cbus_arbiter with NUM_REQ=3
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  cbus_req_t  [NR-1:0] ireqs;
  cbus_resp_t [NR-1:0] iresps;
  cbus_req_t           oreq;
  cbus_resp_t          oresp;
  logic                busy;
  logic [IW-1:0]       grant_idx;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_REQ(NR), .IDX_W(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int          m_left [NR];
  bit          m_drop [NR];
  logic        m_write[NR];
  logic [31:0] m_addr [NR];
  logic [7:0]  m_len  [NR];
  cbus_burst_t m_burst[NR];
  cbus_size_t  m_size [NR];
  logic [7:0]  m_strb [NR];
  logic [63:0] m_wdata[NR];

  int exp_grant[$];
  int grant_log[$];

  int          br_lat = 1;
  logic [63:0] br_base = 64'h0;
  bit          br_active = 0;
  int          br_wait = 0;
  int          br_beat = 0;

  bit          prev_busy = 0, prev_ready = 0, prev_last = 0;
  int          prev_g = 0;
  int          last_grant_cyc = 0, done_cyc = 0, done_g = -1, beats_seen = 0, done_beats = 0;
  logic [63:0] done_data = '0;
  bit          chk_bubble = 0, bubble_arm = 0;

  typedef struct {
    logic [NR-1:0] mask;
    int            n;
    int            g0, g1, g2;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cbus_req_t make_req(input int i);
    cbus_req_t r;
    r          = '0;
    r.valid    = (m_left[i] > 0) && !m_drop[i];
    r.is_write = m_write[i];
    r.size     = m_size[i];
    r.addr     = m_addr[i];
    r.strobe   = m_strb[i];
    r.data     = m_wdata[i];
    r.len      = m_len[i];
    r.burst    = m_burst[i];
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) ireqs[i] = make_req(i);
  endtask

  task automatic setup(input int i, input logic [31:0] addr, input logic [7:0] len, input logic wr,
                       input cbus_burst_t bt, input cbus_size_t sz, input logic [7:0] strb,
                       input logic [63:0] wd);
    m_addr[i] = addr; m_len[i] = len; m_write[i] = wr; m_burst[i] = bt;
    m_size[i] = sz; m_strb[i] = strb; m_wdata[i] = wd;
  endtask

  function automatic bit any_left();
    for (int i = 0; i < NR; i++) if (m_left[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || any_left() || exp_grant.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(n < max, "idle_timeout", 64'(n), 64'(max));
  endtask

  // Per-cycle master, bridge and monitor model, run just after each active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      br_active = 0; prev_busy = 0; prev_ready = 0; prev_last = 0; bubble_arm = 0;
      oresp = '0;
      for (int i = 0; i < NR; i++) begin m_left[i] = 0; m_drop[i] = 0; end
      drive();
      #1;
      check(busy == 1'b0, "reset_busy", 64'(busy), 64'd0);
      check(grant_idx == '0, "reset_grant_idx", 64'(grant_idx), 64'd0);
      check(oreq == '0, "reset_oreq", 64'(oreq.valid), 64'd0);
      check(iresps == '0, "reset_iresps", 64'(iresps[0].ready), 64'd0);
    end else begin
      if (prev_busy && prev_ready && !prev_last) check(busy == 1'b1, "hold_nonlast", 64'(busy), 64'd1);
      if (prev_busy && prev_ready && prev_last) begin
        check(busy == 1'b0, "release", 64'(busy), 64'd0);
        if (m_left[prev_g] > 0) m_left[prev_g]--;
      end
      drive();
      #1;
      if (busy && !prev_busy) begin
        grant_log.push_back(int'(grant_idx));
        last_grant_cyc = cyc;
        beats_seen = 0;
        if (exp_grant.size() > 0) begin
          int e;
          e = exp_grant.pop_front();
          check(int'(grant_idx) == e, "grant_order", 64'(grant_idx), 64'(e));
        end
        if (bubble_arm) begin
          check(cyc - done_cyc == 2, "bubble", 64'(cyc - done_cyc), 64'd2);
          bubble_arm = 0;
        end
      end
      oresp = '0;
      if (oreq.valid && !br_active) begin br_active = 1; br_wait = br_lat; br_beat = 0; end
      if (br_active) begin
        if (br_wait > 0) br_wait--;
        else begin
          oresp.ready = 1'b1;
          oresp.last  = (br_beat == int'(oreq.len));
          oresp.data  = br_base + 64'(br_beat);
          br_beat++;
        end
      end
      #1;
      if (busy) begin
        check(oreq == make_req(int'(grant_idx)), "oreq_mirror", 64'(oreq.addr), 64'(m_addr[grant_idx]));
        check(iresps[grant_idx] == oresp, "iresp_grantee", iresps[grant_idx].data, oresp.data);
        for (int j = 0; j < NR; j++)
          if (j != int'(grant_idx)) check(iresps[j] == '0, "iresp_other_zero", 64'(iresps[j].ready), 64'd0);
        if (oresp.ready) beats_seen++;
        if (oresp.ready && oresp.last) begin
          done_g = int'(grant_idx); done_data = iresps[grant_idx].data;
          done_beats = beats_seen; done_cyc = cyc;
          if (chk_bubble) bubble_arm = 1;
          br_active = 0;
        end
      end else begin
        check(oreq == '0, "idle_oreq_zero", 64'(oreq.valid), 64'd0);
        check(iresps == '0, "idle_iresps_zero", 64'(iresps[0].ready), 64'd0);
      end
      prev_busy = busy; prev_ready = oresp.ready; prev_last = oresp.last; prev_g = int'(grant_idx);
    end
  end

  initial begin
    int req_cyc, n, L, pos;
    ireqs = '0;
    oresp = '0;
    for (int i = 0; i < NR; i++) begin
      m_left[i] = 0; m_drop[i] = 0;
      setup(i, 32'h100 * (i + 1), 8'd0, 1'b0, BURST_FIXED, MSIZE4, 8'h0F, 64'h0);
    end
    vecs[0] = '{3'b011, 2, 0, 1, 0};
    vecs[1] = '{3'b101, 2, 2, 0, 0};
    vecs[2] = '{3'b110, 2, 1, 2, 0};
    vecs[3] = '{3'b111, 3, 0, 1, 2};
    vecs[4] = '{3'b100, 1, 2, 0, 0};
    vecs[5] = '{3'b010, 1, 1, 0, 0};
    vecs[6] = '{3'b011, 2, 0, 1, 0};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Round-robin order table, starting from prio_ptr=0 after reset.
    br_lat = 1; br_base = 64'h5000;
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NR; i++) if (vecs[v].mask[i]) m_left[i] = 1;
      exp_grant.push_back(vecs[v].g0);
      if (vecs[v].n > 1) exp_grant.push_back(vecs[v].g1);
      if (vecs[v].n > 2) exp_grant.push_back(vecs[v].g2);
      drive();
      wait_idle(200);
    end

    // Single read with two-cycle bridge latency.
    setup(0, 32'h8000_0000, 8'd0, 1'b0, BURST_FIXED, MSIZE4, 8'h0F, 64'h0);
    br_lat = 2; br_base = 64'hDEAD_BEEF;
    exp_grant.push_back(0);
    req_cyc = cyc;
    m_left[0] = 1;
    drive();
    wait_idle(100);
    check(last_grant_cyc - req_cyc == 1, "single_latency", 64'(last_grant_cyc - req_cyc), 64'd1);
    check(done_data == 64'hDEAD_BEEF, "single_data", done_data, 64'hDEAD_BEEF);
    check(done_g == 0, "single_grantee", 64'(done_g), 64'd0);

    // Contention from reset: 0 and 1 each three transactions, one bubble between.
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    setup(0, 32'h2000, 8'd0, 1'b0, BURST_FIXED, MSIZE4, 8'h0F, 64'h0);
    setup(1, 32'h3000, 8'd0, 1'b0, BURST_FIXED, MSIZE4, 8'h0F, 64'h0);
    br_lat = 1; br_base = 64'h7700;
    chk_bubble = 1;
    for (int r = 0; r < 3; r++) begin exp_grant.push_back(0); exp_grant.push_back(1); end
    m_left[0] = 3; m_left[1] = 3;
    drive();
    wait_idle(300);
    chk_bubble = 0; bubble_arm = 0;

    // Burst write, four beats, only the last releases.
    setup(1, 32'h0000_4000, 8'd3, 1'b1, BURST_INCR, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788);
    br_lat = 1; br_base = 64'h9900;
    exp_grant.push_back(1);
    m_left[1] = 1;
    drive();
    wait_idle(100);
    check(done_beats == 4, "burst_beats", 64'(done_beats), 64'd4);
    check(done_g == 1, "burst_grantee", 64'(done_g), 64'd1);

    // Starvation: 0 and 2 stream continuously, 1 joins mid-stream.
    setup(0, 32'h10, 8'd0, 1'b0, BURST_FIXED, MSIZE4, 8'h0F, 64'h0);
    setup(2, 32'h30, 8'd1, 1'b0, BURST_INCR, MSIZE4, 8'h0F, 64'h0);
    m_left[0] = 100; m_left[2] = 100;
    drive();
    n = 0;
    L = grant_log.size();
    while (grant_log.size() < L + 5 && n < 200) begin @(negedge clk); n++; end
    check(n < 200, "starve_stream_timeout", 64'(n), 64'd200);
    L = grant_log.size();
    m_left[1] = 1;
    drive();
    n = 0;
    while (m_left[1] > 0 && n < 200) begin @(negedge clk); n++; end
    check(n < 200, "starve_req1_timeout", 64'(n), 64'd200);
    pos = -1;
    for (int k = L; k < grant_log.size(); k++) if (pos < 0 && grant_log[k] == 1) pos = k;
    check(pos >= L && pos - L <= 2, "starve_wait", 64'(pos - L), 64'd2);
    for (int i = 0; i < NR; i++) if (m_left[i] > 1) m_left[i] = 1;
    wait_idle(200);

    // Reset mid-burst: move prio_ptr off zero, then abandon a len-7 burst at beat 2.
    setup(1, 32'h600, 8'd0, 1'b0, BURST_FIXED, MSIZE4, 8'h0F, 64'h0);
    br_lat = 0; br_base = 64'hA000;
    exp_grant.push_back(1);
    m_left[1] = 1;
    drive();
    wait_idle(100);
    setup(0, 32'h700, 8'd7, 1'b0, BURST_INCR, MSIZE8, 8'hFF, 64'h0);
    exp_grant.push_back(0);
    m_left[0] = 1;
    drive();
    n = 0;
    while (!(br_active && br_beat == 3) && n < 100) begin @(negedge clk); n++; end
    check(n < 100, "midburst_timeout", 64'(n), 64'd100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check(busy == 1'b0 && oreq.valid == 1'b0, "midburst_reset", 64'({busy, oreq.valid}), 64'd0);
    setup(2, 32'h800, 8'd0, 1'b0, BURST_FIXED, MSIZE4, 8'h0F, 64'h0);
    exp_grant.push_back(1); exp_grant.push_back(2);
    m_left[1] = 1; m_left[2] = 1;
    drive();
    wait_idle(100);

    // Protocol error: grantee drops valid, grant held until ready&&last.
    setup(2, 32'h900, 8'd1, 1'b0, BURST_INCR, MSIZE4, 8'h0F, 64'h0);
    br_lat = 3; br_base = 64'hB000;
    exp_grant.push_back(2);
    m_left[2] = 1;
    drive();
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    check(n < 20, "proto_grant_timeout", 64'(n), 64'd20);
    m_drop[2] = 1;
    drive();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check(busy == 1'b1 && grant_idx == 2'd2, "proto_hold", 64'({busy, grant_idx}), 64'h6);
    end
    wait_idle(100);
    check(done_g == 2 && done_beats == 2, "proto_release", 64'(done_beats), 64'd2);
    m_drop[2] = 0;
    drive();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
